// File: rtl/rv32i_types.sv
// Shared RV32I core types used by the branch target buffer and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_types;

    localparam int BTB_ENTRIES_DEFAULT = 16;

    // Branch kind recorded with each BTB entry; 2'b11 is never a valid kind.
    typedef enum logic [1:0] {
        op_br   = 2'b00,
        op_jal  = 2'b01,
        op_jalr = 2'b10
    } btb_ops;

    localparam logic [1:0] BTB_OP_ILLEGAL = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target_address;
        logic [1:0]  br_jal_jalr;
    } btb_entry;

    function automatic logic btb_op_legal(input logic [1:0] op);
        return op != BTB_OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/btb_table_if.sv
// Fetch lookup port and resolution update port of the branch target buffer.
// Latency: lookup combinational, update visible after one edge.
// Backpressure: none; every update is accepted.
interface btb_table_if
    import rv32i_types::*;
#(
    parameter int ENTRIES = BTB_ENTRIES_DEFAULT
) ();

    logic [31:0]              lookup_pc;
    logic                     btb_hit;
    btb_entry                 btb_out;
    logic                     upd_valid;
    logic                     upd_inval;
    btb_entry                 upd_entry;
    logic [$clog2(ENTRIES):0] occupancy;

    modport master (
        output lookup_pc, upd_valid, upd_inval, upd_entry,
        input  btb_hit, btb_out, occupancy
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_inval, upd_entry,
        output btb_hit, btb_out, occupancy
    );

endinterface

// File: rtl/btb_table_victim_select.sv
// Chooses the slot a new pc is written to: lowest invalid entry, else the round-robin pointer.
// Latency: combinational.
// Backpressure: none.
module btb_victim_select #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_victim,
    output logic               o_full
);

    // Scan from the top down so the lowest invalid index is the last one kept.
    always_comb begin
        o_full   = &i_valid;
        o_victim = i_ptr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_victim = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/btb_table.sv
// Fully associative, full-pc-tagged branch target buffer held in flops.
// Latency: lookup zero-cycle (with same-cycle update bypass), update lands on the next edge.
// Backpressure: none; an update is taken every cycle upd_valid is high.
module btb_table
    import rv32i_types::*;
#(
    parameter int ENTRIES = BTB_ENTRIES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    btb_table_if.slave   bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    logic [ENTRIES-1:0] r_valid;
    btb_entry           r_ent [ENTRIES];
    logic [IDX_W-1:0]   r_ptr;
    logic [OCC_W-1:0]   r_occ;

    logic               w_tbl_hit;
    btb_entry           w_tbl_out;
    logic               w_upd_hit;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [IDX_W-1:0]   w_victim;
    logic               w_full;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_wr;
    logic               w_inv;
    logic               w_byp;

    btb_victim_select #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_victim (
        .i_valid  (r_valid),
        .i_ptr    (r_ptr),
        .o_victim (w_victim),
        .o_full   (w_full)
    );

    // Table search for fetch; entries are unique so OR-ing matches is a one-hot mux.
    always_comb begin
        w_tbl_hit = 1'b0;
        w_tbl_out = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_ent[i].pc == bus.lookup_pc)) begin
                w_tbl_hit = 1'b1;
                w_tbl_out = w_tbl_out | r_ent[i];
            end
        end
    end

    // Locate an existing entry for the update pc (overwrite or invalidate target).
    always_comb begin
        w_upd_hit = 1'b0;
        w_upd_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_ent[i].pc == bus.upd_entry.pc)) begin
                w_upd_hit = 1'b1;
                w_upd_idx = IDX_W'(i);
            end
        end
    end

    assign w_wr     = bus.upd_valid && !bus.upd_inval && btb_op_legal(bus.upd_entry.br_jal_jalr);
    assign w_inv    = bus.upd_valid && bus.upd_inval;
    assign w_byp    = bus.upd_valid && (bus.upd_entry.pc == bus.lookup_pc);
    assign w_wr_idx = w_upd_hit ? w_upd_idx : w_victim;

    // Same-cycle bypass lets fetch see a write or invalidate before it reaches the table.
    always_comb begin
        bus.btb_hit = w_tbl_hit;
        bus.btb_out = w_tbl_out;
        if (w_byp && w_wr) begin
            bus.btb_hit = 1'b1;
            bus.btb_out = bus.upd_entry;
        end else if (w_byp && w_inv) begin
            bus.btb_hit = 1'b0;
            bus.btb_out = '0;
        end
    end

    assign bus.occupancy = r_occ;

    // Entry payload; no reset needed because valid bits gate every read.
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_ent[w_wr_idx] <= bus.upd_entry;
        end
    end

    // Valid bits, replacement pointer and occupancy; reset drops any concurrent update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ptr   <= '0;
            r_occ   <= '0;
        end else if (w_wr && !w_upd_hit) begin
            r_valid[w_victim] <= 1'b1;
            if (w_full) begin
                r_ptr <= r_ptr + IDX_W'(1);
            end else begin
                r_occ <= r_occ + OCC_W'(1);
            end
        end else if (w_inv && w_upd_hit) begin
            r_valid[w_upd_idx] <= 1'b0;
            r_occ              <= r_occ - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_btb_table.sv
// Directed and random stimulus for btb_table against a behavioural table model.
// Latency: checks lookup outputs mid-cycle, before the edge that commits the update.
// Backpressure: n/a.
module tb_btb_table;
    import rv32i_types::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btb_table_if #(.ENTRIES(N)) bus ();

    btb_table #(.ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: a list of slots with a valid flag and the replacement pointer.
    bit       m_vld [N];
    btb_entry m_ent [N];
    int       m_ptr;

    int tests = 0;
    int fails = 0;

    function automatic int m_occ();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_vld[i] ? 1 : 0;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_apply(input logic r, input logic v, input logic inv, input btb_entry e);
        int slot;
        if (r) begin
            for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
            m_ptr = 0;
            return;
        end
        if (!v) return;
        slot = -1;
        for (int i = 0; i < N; i++) if (m_vld[i] && m_ent[i].pc == e.pc) slot = i;
        if (inv) begin
            if (slot >= 0) m_vld[slot] = 1'b0;
            return;
        end
        if (e.br_jal_jalr == 2'b11) return;
        if (slot < 0) begin
            for (int i = N - 1; i >= 0; i--) if (!m_vld[i]) slot = i;
        end
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % N;
        end
        m_vld[slot] = 1'b1;
        m_ent[slot] = e;
    endtask

    // One clock of stimulus: drive, check outputs against the model mid-cycle, commit.
    task automatic step(input logic r, input logic v, input logic inv, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [1:0] op, input logic [31:0] lk,
                        input string tag);
        btb_entry e;
        logic     eh;
        btb_entry eo;
        e.pc             = pc;
        e.target_address = tgt;
        e.br_jal_jalr    = op;
        rst           = r;
        bus.upd_valid = v;
        bus.upd_inval = inv;
        bus.upd_entry = e;
        bus.lookup_pc = lk;
        @(negedge clk);
        if (!r) begin
            eh = 1'b0;
            eo = '0;
            for (int i = 0; i < N; i++) begin
                if (m_vld[i] && m_ent[i].pc == lk) begin
                    eh = 1'b1;
                    eo = m_ent[i];
                end
            end
            if (v && pc == lk) begin
                if (inv) begin
                    eh = 1'b0;
                    eo = '0;
                end else if (op != 2'b11) begin
                    eh = 1'b1;
                    eo = e;
                end
            end
            chk({tag, ".hit"}, 66'(bus.btb_hit), 66'(eh));
            chk({tag, ".out"}, bus.btb_out, eo);
            chk({tag, ".occ"}, 66'(bus.occupancy), 66'(m_occ()));
        end
        @(posedge clk);
        m_apply(r, v, inv, e);
        #1;
    endtask

    // Idle cycle with lookup checked against hand-written constants.
    task automatic probe(input logic [31:0] lk, input logic eh, input logic [31:0] etgt,
                         input logic [1:0] eop, input int eocc, input string tag);
        btb_entry eo;
        eo.pc             = lk;
        eo.target_address = etgt;
        eo.br_jal_jalr    = eop;
        if (!eh) eo = '0;
        rst           = 1'b0;
        bus.upd_valid = 1'b0;
        bus.upd_inval = 1'b0;
        bus.upd_entry = '0;
        bus.lookup_pc = lk;
        @(negedge clk);
        chk({tag, ".hit"}, 66'(bus.btb_hit), 66'(eh));
        chk({tag, ".out"}, bus.btb_out, eo);
        chk({tag, ".occ"}, 66'(bus.occupancy), 66'(eocc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.upd_valid = 1'b0;
        bus.upd_inval = 1'b0;
        bus.upd_entry = '0;
        bus.lookup_pc = '0;
        m_ptr         = 0;
        #1;

        step(1, 0, 0, 0, 0, 2'b00, 32'h60, "rst0");
        step(1, 0, 0, 0, 0, 2'b00, 32'h60, "rst1");
        probe(32'h60, 0, 0, 2'b00, 0, "reset_lookup");

        step(0, 1, 0, 32'h60, 32'h80, op_br, 32'h60, "wr60_bypass");
        probe(32'h60, 1, 32'h80, op_br, 1, "rd60");
        step(0, 1, 0, 32'h60, 32'h100, op_jal, 32'h64, "ovw60");
        probe(32'h60, 1, 32'h100, op_jal, 1, "rd60_ovw");

        step(1, 0, 0, 0, 0, 2'b00, 0, "rst2");
        for (int i = 0; i < N; i++) begin
            step(0, 1, 0, 32'(i * 4), 32'(32'h1000 + i * 4), op_br, 32'(i * 4), "fill");
        end
        probe(32'h3C, 1, 32'h103C, op_br, 16, "full_last");
        step(0, 1, 0, 32'h200, 32'h2200, op_jalr, 32'h0, "evict0");
        probe(32'h0, 0, 0, 2'b00, 16, "evicted0");
        probe(32'h200, 1, 32'h2200, op_jalr, 16, "new200");
        probe(32'h4, 1, 32'h1004, op_br, 16, "kept4");
        step(0, 1, 0, 32'h204, 32'h2204, op_br, 32'h4, "evict1");
        probe(32'h4, 0, 0, 2'b00, 16, "evicted4");
        probe(32'h8, 1, 32'h1008, op_br, 16, "kept8");

        step(0, 1, 1, 32'h10, 32'h0, op_br, 32'h10, "inval10_bypass");
        probe(32'h10, 0, 0, 2'b00, 15, "inval10");
        step(0, 1, 0, 32'h300, 32'h3300, op_jal, 32'h0, "refill");
        probe(32'h300, 1, 32'h3300, op_jal, 16, "rd300");
        probe(32'h8, 1, 32'h1008, op_br, 16, "ptr_unmoved");
        step(0, 1, 0, 32'h304, 32'h3304, op_br, 32'h0, "evict2");
        probe(32'h8, 0, 0, 2'b00, 16, "evicted8");
        probe(32'hC, 1, 32'h100C, op_br, 16, "keptC");

        step(0, 1, 0, 32'h400, 32'h4400, 2'b11, 32'h400, "illegal_new");
        probe(32'h400, 0, 0, 2'b00, 16, "illegal_absent");
        step(0, 1, 0, 32'hC, 32'hDEAD, 2'b11, 32'hC, "illegal_existing");
        probe(32'hC, 1, 32'h100C, op_br, 16, "illegal_noop");

        step(1, 1, 0, 32'h500, 32'h5500, op_br, 32'h500, "rst_with_wr");
        probe(32'h500, 0, 0, 2'b00, 0, "rst_drop_wr");
        probe(32'h300, 0, 0, 2'b00, 0, "rst_empty");

        for (int k = 0; k < 400; k++) begin
            step(logic'($urandom_range(0, 99) == 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 4) == 0),
                 32'($urandom_range(0, 31) * 4),
                 $urandom,
                 2'($urandom_range(0, 3)),
                 32'($urandom_range(0, 31) * 4),
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
